// File: rtl/x_multdiv_unit_pkg.sv
// Shared constants and types for the execute-stage multiply/divide unit.
package x_multdiv_unit_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/x_multdiv_unit_if.sv
// Bundle between the X stage and the multiply/divide unit.
interface x_multdiv_unit_if;
  import x_multdiv_unit_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             stall;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, stall
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, stall
  );

endinterface

// File: rtl/x_multdiv_unit_datapath.sv
// Magnitude datapath: shift-add multiply (LSB first) and restoring divide
// (MSB first), one bit per step, plus the signed-32-bit overflow check.
module md_iter_datapath
  import x_multdiv_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  op_t              op,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  input  logic             neg,
  output logic [WIDTH-1:0] mag_result,
  output logic             overflow
);

  op_t                op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   opnd_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic               rem_fits;

  // Next-step arithmetic: partial-product add and trial subtraction.
  always_comb begin
    add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    rem_diff  = rem_shift - {2'b00, opnd_q};
    rem_fits  = (rem_shift >= {2'b00, opnd_q});
  end

  // Magnitude registers; the multiplier shares the low half of the product.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= OP_MUL;
      prod_q <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      opnd_q <= '0;
    end else if (load) begin
      op_q  <= op;
      rem_q <= '0;
      if (op == OP_MUL) begin
        prod_q <= {{WIDTH{1'b0}}, b_mag};
        quot_q <= '0;
        opnd_q <= a_mag;
      end else begin
        prod_q <= '0;
        quot_q <= a_mag;
        opnd_q <= b_mag;
      end
    end else if (step) begin
      if (op_q == OP_MUL) begin
        if (prod_q[0]) begin
          prod_q <= {add_sum, prod_q[WIDTH-1:1]};
        end else begin
          prod_q <= {1'b0, prod_q[2*WIDTH-1:1]};
        end
      end else if (rem_fits) begin
        rem_q  <= (WIDTH+1)'(rem_diff);
        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q  <= (WIDTH+1)'(rem_shift);
        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // A negative result may reach 2^31; a non-negative one must stay below it.
  always_comb begin
    mag_result = (op_q == OP_MUL) ? prod_q[WIDTH-1:0] : quot_q;
    overflow   = ((op_q == OP_MUL) && (|prod_q[2*WIDTH-1:WIDTH])) ||
                 (mag_result[WIDTH-1] && (!neg || (|mag_result[WIDTH-2:0])));
  end

endmodule

// File: rtl/x_multdiv_unit.sv
// Execute-stage iterative multiply/divide unit: FSM, pipeline stall,
// sign handling and exception select around the magnitude datapath.
module x_multdiv_unit
  import x_multdiv_unit_pkg::*;
(
  input logic          clock,
  input logic          reset,
  x_multdiv_unit_if.slave md
);

  state_t           state;
  op_t              op_q;
  logic [5:0]       counter;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero_q;
  logic             rdy_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             start;
  op_t              start_op;
  logic             load;
  logic             neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mag_result;
  logic             overflow;
  logic [WIDTH-1:0] signed_val;
  logic             div_zero;
  logic [WIDTH-1:0] final_result;
  logic             final_exc;

  // Start decode and operand magnitudes; MULT wins when both are pulsed.
  always_comb begin
    start    = md.ctrl_MULT | md.ctrl_DIV;
    start_op = md.ctrl_MULT ? OP_MUL : OP_DIV;
    load     = (state == IDLE) && start;
    a_mag    = md.data_operandA[WIDTH-1] ? -md.data_operandA : md.data_operandA;
    b_mag    = md.data_operandB[WIDTH-1] ? -md.data_operandB : md.data_operandB;
    neg      = sign_a ^ sign_b;
  end

  md_iter_datapath u_datapath (
    .clock      (clock),
    .reset      (reset),
    .op         (start_op),
    .load       (load),
    .step       (state == RUN),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .neg        (neg),
    .mag_result (mag_result),
    .overflow   (overflow)
  );

  // Apply the result sign and pick the exception source.
  always_comb begin
    signed_val   = neg ? -mag_result : mag_result;
    div_zero     = (op_q == OP_DIV) && b_zero_q;
    final_result = div_zero ? '0 : signed_val;
    final_exc    = div_zero | overflow;
  end

  // Control FSM: IDLE -> RUN for ITER steps -> one DONE cycle -> IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      counter  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero_q <= 1'b0;
      rdy_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b0;
          if (start) begin
            op_q     <= start_op;
            sign_a   <= md.data_operandA[WIDTH-1];
            sign_b   <= md.data_operandB[WIDTH-1];
            b_zero_q <= (md.data_operandB == '0);
            counter  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          counter <= counter + 6'd1;
          if (counter == 6'(ITER - 1)) begin
            rdy_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          result_q <= final_result;
          exc_q    <= final_exc;
          rdy_q    <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          rdy_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign md.stall          = (state == RUN) || load;
  assign md.data_resultRDY = rdy_q;
  assign md.data_result    = (state == DONE) ? final_result : result_q;
  assign md.data_exception = (state == DONE) ? final_exc : exc_q;

endmodule

// File: tb/tb_x_multdiv_unit.sv
// Directed bench for x_multdiv_unit with a result scoreboard and cycle checks.
module tb_x_multdiv_unit;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    int          rdy_cyc;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   stall_cnt;
  exp_t sb[$];

  x_multdiv_unit_if bus ();

  x_multdiv_unit dut (
    .clock (clock),
    .reset (reset),
    .md    (bus)
  );

  // Free-running clock and cycle index.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with wide signed arithmetic.
  function automatic exp_t model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    int     ia;
    int     ib;
    longint p;
    ia = a;
    ib = b;
    e.rdy_cyc = 0;
    if (is_mul) begin
      p = longint'(ia) * longint'(ib);
      e.result = p[31:0];
      e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (ib == 0) begin
      e.result = 32'h0;
      e.exc = 1'b1;
    end else if (a == 32'h80000000 && ib == -1) begin
      e.result = 32'h80000000;
      e.exc = 1'b1;
    end else begin
      e.result = ia / ib;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Called #1 after a rising edge; pulses the start for exactly one cycle.
  task automatic applyStimulus(input logic mul, input logic div, input logic [31:0] a,
                               input logic [31:0] b, input logic push);
    exp_t e;
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (push) begin
      e = model(mul, a, b);
      e.rdy_cyc = cyc + 33;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  task automatic waitForDrain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL %s timeout pending=%0d expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: compares every RDY pulse against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      stall_cnt = 0;
    end else begin
      if (bus.stall) stall_cnt++;
      if (bus.data_resultRDY) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_rdy cycle=%0d result=0x%08h expected no pulse", cyc, bus.data_result);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("result", bus.data_result, e.result);
          checkOutput("exception", 32'(bus.data_exception), 32'(e.exc));
          checkOutput("rdy_cycle", 32'(cyc), 32'(e.rdy_cyc));
          checkOutput("stall_cycles", 32'(stall_cnt), 32'd33);
          checkOutput("stall_at_rdy", 32'(bus.stall), 32'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    stall_cnt = 0;
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'h0;
    bus.data_operandB = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_result", bus.data_result, 32'h0);
    checkOutput("reset_exc", 32'(bus.data_exception), 32'h0);
    checkOutput("reset_rdy", 32'(bus.data_resultRDY), 32'h0);
    checkOutput("reset_stall", 32'(bus.stall), 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] multiply cases");
    applyStimulus(1'b1, 1'b0, 32'd7, -32'sd6, 1'b1);
    waitForDrain("mul_7x-6");
    applyStimulus(1'b1, 1'b0, 32'h00010000, 32'h00010000, 1'b1);
    waitForDrain("mul_overflow");
    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'd1, 1'b1);
    waitForDrain("mul_min");

    $display("[TB] divide cases");
    applyStimulus(1'b0, 1'b1, -32'sd7, 32'd2, 1'b1);
    waitForDrain("div_-7/2");
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd0, 1'b1);
    waitForDrain("div_zero");
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    waitForDrain("div_min_by_-1");

    $display("[TB] both starts, and a start ignored during RUN");
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd3, 1'b1);
    repeat (9) @(posedge clock);
    #1;
    applyStimulus(1'b0, 1'b1, 32'd50, 32'd7, 1'b0);
    waitForDrain("both_start");
    repeat (40) @(posedge clock);
    #1;

    $display("[TB] reset abort during divide");
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort_result", bus.data_result, 32'h0);
    checkOutput("abort_exc", 32'(bus.data_exception), 32'h0);
    checkOutput("abort_rdy", 32'(bus.data_resultRDY), 32'h0);
    checkOutput("abort_stall", 32'(bus.stall), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 1'b1);
    waitForDrain("mul_after_abort");

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd5, 1'b1);
    waitForDrain("b2b_mul");
    applyStimulus(1'b0, 1'b1, 32'd25, 32'd5, 1'b1);
    waitForDrain("b2b_div");
    repeat (2) @(posedge clock);
    #1;
    checkOutput("hold_result", bus.data_result, 32'd5);
    checkOutput("hold_exc", 32'(bus.data_exception), 32'd0);

    $display("[TB] random operands");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], ~i[0], $urandom(), (i < 4) ? $urandom() : $urandom_range(1, 300), 1'b1);
      waitForDrain("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_multdiv_unit.md
Name: x_multdiv_unit

Overview:
- Execute-stage iterative multiply/divide unit.
- Sits between the DX latch and the XM latch. Consumes operands when a MUL or DIV instruction is decoded in X.
- Produces a 32-bit result and an exception flag that feed XM's ALU-output and exception inputs.
- Drives the pipeline stall that freezes the PC, FD, DX and XM until the result is ready.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration cycles per operation; equals WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  start signed multiply; 1-cycle pulse from the X-stage decode.
- ctrl_DIV  input  1  start signed divide; 1-cycle pulse.
- data_operandA  input  32  multiplicand/dividend. Sampled only on the start cycle.
- data_operandB  input  32  multiplier/divisor. Sampled only on the start cycle.
- data_result  output  32  result. Valid only while data_resultRDY=1.
- data_exception  output  1  overflow or divide error. Valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse marking the result cycle.
- stall  output  1  high from the start cycle through the cycle before data_resultRDY.

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset: state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, stall=0; all internal registers cleared. Reset mid-operation aborts it with no RDY pulse. Reset has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start = ctrl_MULT | ctrl_DIV. If both are high, MULT wins.
  - On start: latch operands and op, record sign of each operand, load their magnitudes (|-2^31| = 0x80000000 unsigned), counter=0, go to RUN.
  - stall is combinationally high in the start cycle.
- RUN:
  - One iteration per cycle; counter increments.
  - After the iteration with counter=ITER-1, go to DONE.
  - stall=1 throughout.
  - Start pulses while in RUN or DONE are ignored.
- Multiply: unsigned shift-add on magnitudes into a 64-bit product register. One multiplier bit per cycle, LSB first.
- Divide: restoring division on magnitudes. 32-bit quotient, 33-bit partial remainder, one quotient bit per cycle, MSB first.
- DONE (one cycle): data_resultRDY=1, stall=0, then return to IDLE.
  - Result sign = signA XOR signB; the magnitude is negated (two's complement) when negative.
  - MUL: data_result = low 32 bits of the signed product.
  - MUL exception=1 when the product does not fit in signed 32 bits, i.e. magnitude > 2^31-1 for a non-negative result or > 2^31 for a negative result.
  - DIV: quotient truncates toward zero; the remainder is discarded.
  - DIV by zero: exception=1, result=0.
  - DIV of -2^31 / -1: exception=1, result=0x80000000.
- Latency is fixed regardless of operand values:
  - start at cycle 0, RUN cycles 1..32, RDY in cycle 33.
  - stall is high in cycles 0..32.
  - XM captures the result in cycle 33, when stall=0.
- A new start is accepted in the cycle after DONE at the earliest.
- data_result and data_exception hold their last DONE value until the next DONE or reset. Consumers qualify them with data_resultRDY.
- Widths: internal product 64 bits; divider remainder 33 bits; counter 6 bits; no truncation before the final select.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), ITER, WIDTH, op-select constants (OP_MUL, OP_DIV).
- One natural sub-module, md_iter_datapath, holding the magnitude registers and the shift-add/restoring-subtract step. It takes op, load, step, done-sign and produces magnitude result and overflow.
- The FSM, stall, sign handling and exception select stay in x_multdiv_unit.

Test Plan:
- MULT A=7, B=-6 -> after 33 cycles RDY=1, result=0xFFFFFFD6 (-42), exception=0; stall high exactly 33 cycles (0..32).
- MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. MULT A=0x80000000, B=1 -> result=0x80000000, exception=0.
- DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. DIV A=100, B=0 -> result=0, exception=1. DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_MULT and ctrl_DIV both high with A=6, B=3 -> result=18 (multiply). A start pulse at cycle 10 of RUN is ignored: exactly one RDY, at cycle 33.
- Reset asserted at cycle 15 of a DIV -> next cycle state IDLE, outputs 0, no RDY. A new MULT 3x4 then yields 12 after 33 cycles.
- Back-to-back: MULT 5x5 followed by ctrl_DIV 25/5 issued in the cycle after RDY -> RDY pulses at cycles 33 and 67 with results 25 and 5.
